// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port among NUM_REQ requesters.
// Define MEM_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module mem_port_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   s_req_vld,
   output logic [NUM_REQ-1:0]                   s_req_rdy,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]        s_req_addr,
   output logic [NUM_REQ-1:0]                   s_rsp_vld,
   output logic [DATA_WIDTH-1:0]                s_rsp_data,
   output logic                                 m_req_vld,
   input  logic                                 m_req_rdy,
   output logic [ADDR_WIDTH-1:0]                m_req_addr,
   input  logic                                 m_rsp_vld,
   input  logic [DATA_WIDTH-1:0]                m_rsp_data,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
   output logic                                 rsp_err
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]                grant_cnt,
   output logic [15:0]                          stall_cnt
`endif
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0] locked_id_q, locked_id_d;
   logic           lock_q, lock_d;
   logic [IDW-1:0] arb_id, grant;
   logic [IDW-1:0] id_mem_q [MAX_OUTSTANDING];
   logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]  count_q, count_d;
   logic           rsp_err_q;
   logic           fifo_full, fifo_empty, accept, pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
   endfunction

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin : arb_search
      logic [IDW:0] cand;
      logic         found;
      cand   = '0;
      found  = 1'b0;
      arb_id = rr_ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
         if (!found && s_req_vld[cand[IDW-1:0]]) begin
            found  = 1'b1;
            arb_id = cand[IDW-1:0];
         end
      end
   end

   assign grant      = lock_q ? locked_id_q : arb_id;
   assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
   assign fifo_empty = (count_q == '0);
   assign m_req_vld  = !rst && s_req_vld[grant] && !fifo_full;
   assign m_req_addr = s_req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
   assign accept     = m_req_vld && m_req_rdy;
   assign pop        = !rst && m_rsp_vld && !fifo_empty;
   assign s_rsp_data = m_rsp_data;
   assign outstanding = count_q;
   assign rsp_err    = rsp_err_q;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign s_req_rdy[gi] = !rst && (grant == IDW'(gi)) && m_req_rdy && !fifo_full;
         assign s_rsp_vld[gi] = pop && (id_mem_q[rd_ptr_q] == IDW'(gi));
      end
   endgenerate

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      lock_d      = lock_q;
      locked_id_d = locked_id_q;
      count_d     = count_q;
      if (accept) begin
         rr_ptr_d = (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + IDW'(1);
         lock_d   = 1'b0;
      end else if (m_req_vld) begin
         lock_d      = 1'b1;
         locked_id_d = grant;
      end
      if (accept && !pop)      count_d = count_q + CW'(1);
      else if (!accept && pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         lock_q      <= 1'b0;
         locked_id_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         lock_q      <= lock_d;
         locked_id_q <= locked_id_d;
         count_q     <= count_d;
         if (accept) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
         // A response with nothing in flight is an error even if a push lands this cycle.
         if (m_rsp_vld && fifo_empty) rsp_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) id_mem_q[wr_ptr_q] <= grant;
   end

`ifdef MEM_ARB_STATS_EN
   logic [15:0] stall_cnt_q;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
         logic [15:0] grant_cnt_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               grant_cnt_q <= '0;
            end else if (accept && (grant == IDW'(gi)) && (grant_cnt_q != 16'hFFFF)) begin
               grant_cnt_q <= grant_cnt_q + 16'd1;
            end
         end
         assign grant_cnt[gi*16 +: 16] = grant_cnt_q;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if ((|s_req_vld) && !accept && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked each cycle against a queue-based reference model.
module tb_mem_port_arbiter;

   localparam int N    = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 4;
   localparam int CW   = $clog2(MAXO + 1);

   logic              clk, rst;
   logic [N-1:0]      s_req_vld, s_req_rdy, s_rsp_vld;
   logic [N*AW-1:0]   s_req_addr;
   logic [DW-1:0]     s_rsp_data, m_rsp_data;
   logic              m_req_vld, m_req_rdy, m_rsp_vld, rsp_err;
   logic [AW-1:0]     m_req_addr;
   logic [CW-1:0]     outstanding;
`ifdef MEM_ARB_STATS_EN
   logic [N*16-1:0]   grant_cnt;
   logic [15:0]       stall_cnt;
`endif

   mem_port_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_req_vld(s_req_vld), .s_req_rdy(s_req_rdy), .s_req_addr(s_req_addr),
      .s_rsp_vld(s_rsp_vld), .s_rsp_data(s_rsp_data),
      .m_req_vld(m_req_vld), .m_req_rdy(m_req_rdy), .m_req_addr(m_req_addr),
      .m_rsp_vld(m_rsp_vld), .m_rsp_data(m_rsp_data),
      .outstanding(outstanding), .rsp_err(rsp_err)
`ifdef MEM_ARB_STATS_EN
      , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: in-flight IDs as a queue, round-robin pointer as an integer,
   // and the rule that an offered-but-refused request keeps its grant.
   int           mq[$];
   int           m_rr = 0;
   bit           m_held = 0;
   int           m_held_id = 0;
   bit           m_err = 0;
   int           m_gcnt[N];
   int           m_stall = 0;
   logic [N-1:0] m_acc = '0;
   int           g;
   bit           full_e, mvld_e, acc_e;
   logic [N-1:0] rsp_e;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_m_req_vld", m_req_vld, 0);
         check("rst_s_req_rdy", s_req_rdy, 0);
         check("rst_s_rsp_vld", s_rsp_vld, 0);
         check("rst_outstanding", outstanding, 0);
         check("rst_rsp_err", rsp_err, 0);
         mq.delete();
         m_rr = 0; m_held = 0; m_err = 0; m_stall = 0; m_acc = '0;
         for (int i = 0; i < N; i++) m_gcnt[i] = 0;
      end else begin
         if (m_held) begin
            g = m_held_id;
         end else begin
            g = -1;
            for (int k = 0; k < N; k++)
               if (g < 0 && s_req_vld[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g < 0) g = m_rr;
         end
         full_e = (mq.size() == MAXO);
         mvld_e = s_req_vld[g] && !full_e;
         check("m_req_vld", m_req_vld, mvld_e);
         if (mvld_e) check("m_req_addr", m_req_addr, s_req_addr[g*AW +: AW]);
         if (|s_req_vld) check("s_req_rdy", s_req_rdy, (m_req_rdy && !full_e) ? (64'd1 << g) : 64'd0);
         rsp_e = '0;
         if (m_rsp_vld && mq.size() > 0) rsp_e[mq[0]] = 1'b1;
         check("s_rsp_vld", s_rsp_vld, rsp_e);
         if (rsp_e != '0) begin
            check("s_rsp_data", s_rsp_data, m_rsp_data);
            $display("rsp to requester %0d data %h outstanding %0d", mq[0], m_rsp_data, mq.size());
         end
         check("outstanding", outstanding, mq.size());
         check("rsp_err", rsp_err, m_err);
`ifdef MEM_ARB_STATS_EN
         for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*16 +: 16], m_gcnt[i]);
         check("stall_cnt", stall_cnt, m_stall);
`endif
         acc_e = mvld_e && m_req_rdy;
         m_acc = '0;
         if (acc_e) m_acc[g] = 1'b1;
         if (m_rsp_vld) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else m_err = 1;
         end
         if (acc_e) begin
            mq.push_back(g);
            m_rr = (g + 1) % N;
            m_held = 0;
            if (m_gcnt[g] < 65535) m_gcnt[g]++;
         end else if (mvld_e) begin
            m_held = 1;
            m_held_id = g;
         end
         if ((|s_req_vld) && !acc_e && m_stall < 65535) m_stall++;
      end
   end

   // Drive one cycle of inputs just after the edge; returns mid-cycle for literal checks.
   task automatic drive(input logic [N-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic rdy, input logic rv, input logic [DW-1:0] rd);
      @(posedge clk);
      #1;
      s_req_vld  = v;
      s_req_addr = {a1, a0};
      m_req_rdy  = rdy;
      m_rsp_vld  = rv;
      m_rsp_data = rd;
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      s_req_vld = '1;
      m_req_rdy = 1'b1;
      m_rsp_vld = 1'b1;
      #2;
      check("reset_gates_m_req_vld", m_req_vld, 0);
      check("reset_clears_rsp_err", rsp_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      s_req_vld = '0;
      m_req_rdy = 1'b0;
      m_rsp_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      s_req_vld = '0; s_req_addr = '0; m_req_rdy = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0;
      do_reset();

      // Single requester, response two cycles later
      drive(2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
      check("single_addr", m_req_addr, 32'h10);
      check("single_rdy", s_req_rdy, 2'b01);
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hAB);
      check("single_rsp_vld", s_rsp_vld, 2'b01);
      check("single_rsp_data", s_rsp_data, 32'hAB);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

      // Alternating grants and routed responses
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
         check("alt_grant", s_req_rdy, (k % 2 == 0) ? 2'b01 : 2'b10);
         check("alt_addr", m_req_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      end
      for (int k = 0; k < 4; k++) begin
         drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'hC0 + k);
         if (k == 0) check("alt_full_count", outstanding, 4);
         check("alt_route", s_rsp_vld, (k % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Stall locks the grant on requester 1
      do_reset();
      drive(2'b10, 32'h400, 32'h300, 1'b0, 1'b0, 32'h0);
      check("stall_addr0", m_req_addr, 32'h300);
      drive(2'b11, 32'h400, 32'h300, 1'b0, 1'b0, 32'h0);
      check("stall_addr1", m_req_addr, 32'h300);
      check("stall_rdy", s_req_rdy, 2'b00);
      drive(2'b11, 32'h400, 32'h300, 1'b0, 1'b0, 32'h0);
      check("stall_addr2", m_req_addr, 32'h300);
      drive(2'b11, 32'h400, 32'h300, 1'b1, 1'b0, 32'h0);
      check("stall_accept1", s_req_rdy, 2'b10);
      drive(2'b01, 32'h400, 32'h300, 1'b1, 1'b0, 32'h0);
      check("stall_accept0", s_req_rdy, 2'b01);
      check("stall_addr_req0", m_req_addr, 32'h400);

      // Fill the ID FIFO, then free one slot
      do_reset();
      for (int k = 0; k < 4; k++) drive(2'b01, 32'h10 + k, 32'h0, 1'b1, 1'b0, 32'h0);
      drive(2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
      check("full_count", outstanding, 4);
      check("full_m_req_vld", m_req_vld, 0);
      check("full_rdy", s_req_rdy, 2'b00);
      drive(2'b01, 32'h20, 32'h0, 1'b1, 1'b1, 32'h5A);
      check("full_rsp", s_rsp_vld, 2'b01);
      drive(2'b01, 32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
      check("after_pop_count", outstanding, 3);
      check("after_pop_rdy", s_req_rdy, 2'b01);

      // Response with nothing in flight
      do_reset();
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55);
      check("err_no_route", s_rsp_vld, 2'b00);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("err_set", rsp_err, 1);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("err_held", rsp_err, 1);

      // Same-cycle push and pop at two outstanding
      do_reset();
      drive(2'b11, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0);
      drive(2'b11, 32'h500, 32'h600, 1'b1, 1'b0, 32'h0);
      drive(2'b01, 32'h510, 32'h600, 1'b1, 1'b1, 32'h77);
      check("pp_count_before", outstanding, 2);
      check("pp_route_older", s_rsp_vld, 2'b01);
      check("pp_accept", s_req_rdy, 2'b01);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("pp_count_after", outstanding, 2);

      // Randomized traffic with a mid-transfer reset
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1500) begin
            do_reset();
            continue;
         end
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!(s_req_vld[i] && !m_acc[i])) begin
               s_req_vld[i] = ($urandom % 3) != 0;
               s_req_addr[i*AW +: AW] = $urandom;
            end
         end
         m_req_rdy  = ($urandom % 4) != 0;
         m_rsp_vld  = (mq.size() > 0) && ($urandom % 2 == 1);
         m_rsp_data = $urandom;
      end
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
